stack_sequencer: RTL and testbench

Initiator side of the 8-bit, 32-entry operand stack interface. Accepts one stack-machine command at a time from the multicycle controller and turns it into a legal sequence of single-cycle `push` / `pop` / `tos` strobes. It captures the stack's registered `dout`, computes ALU-style results, and reports done, result and error. It also keeps a shadow depth count so underflow and overflow are caught before any strobe reaches the stack.

---
 rtl/stack_sequencer.sv | 153 +++++++++++++++
 tb/tb_stack_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// stack_sequencer: expands one stack-machine command into single-cycle push/pop/tos strobes,
// captures popped operands, computes the result and guards depth against under/overflow.
module stack_sequencer #(
   parameter  int DATA_W  = 8,
   parameter  int DEPTH   = 32,
   localparam int DEPTH_W = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [2:0]         op,
   input  logic [DATA_W-1:0]  imm,
   output logic               busy,
   output logic               done,
   output logic [DATA_W-1:0]  result,
   output logic               err,
   output logic [DEPTH_W-1:0] depth,
   output logic [DATA_W-1:0]  stk_din,
   output logic               stk_push,
   output logic               stk_pop,
   output logic               stk_tos,
   input  logic [DATA_W-1:0]  stk_dout
);

   localparam logic [2:0] OP_PUSH = 3'd0;
   localparam logic [2:0] OP_POP  = 3'd1;
   localparam logic [2:0] OP_TOS  = 3'd2;
   localparam logic [2:0] OP_ADD  = 3'd3;
   localparam logic [2:0] OP_SUB  = 3'd4;
   localparam logic [2:0] OP_AND  = 3'd5;
   localparam logic [2:0] OP_NOT  = 3'd6;
   localparam logic [2:0] OP_DUP  = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE, S_POPA, S_TOSA, S_CAPA, S_POPB, S_CAPB, S_PUSHR, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          op_q;
   logic [DATA_W-1:0]   imm_q, a_q, b_q, result_q, push_val;
   logic                err_q;
   logic [DEPTH_W-1:0]  depth_q, depth_d;
   logic                has1, has2, room, cmd_ok, accept, op_q_alu, op_q_read;

   assign has1      = depth_q != '0;
   assign has2      = depth_q > DEPTH_W'(1);
   assign room      = depth_q < DEPTH_W'(DEPTH);
   assign accept    = (state_q == S_IDLE) && start;
   assign op_q_alu  = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_AND);
   assign op_q_read = (op_q == OP_POP) || (op_q == OP_TOS);

   always_comb begin
      cmd_ok = 1'b0;
      case (op)
         OP_PUSH:                cmd_ok = room;
         OP_POP, OP_TOS, OP_NOT: cmd_ok = has1;
         OP_ADD, OP_SUB, OP_AND: cmd_ok = has2;
         OP_DUP:                 cmd_ok = has1 && room;
         default:                cmd_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (!cmd_ok) begin
                  state_d = S_DONE;
               end else begin
                  case (op)
                     OP_PUSH:        state_d = S_PUSHR;
                     OP_TOS, OP_DUP: state_d = S_TOSA;
                     default:        state_d = S_POPA;
                  endcase
               end
            end
         end
         S_POPA, S_TOSA: state_d = S_CAPA;
         S_CAPA: begin
            if (op_q_read)     state_d = S_DONE;
            else if (op_q_alu) state_d = S_POPB;
            else               state_d = S_PUSHR;
         end
         S_POPB:  state_d = S_CAPB;
         S_CAPB:  state_d = S_PUSHR;
         S_PUSHR: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // a is the first value popped (top), b the one beneath it
   always_comb begin
      push_val = a_q;
      case (op_q)
         OP_PUSH: push_val = imm_q;
         OP_ADD:  push_val = b_q + a_q;
         OP_SUB:  push_val = b_q - a_q;
         OP_AND:  push_val = b_q & a_q;
         OP_NOT:  push_val = ~a_q;
         default: push_val = a_q;
      endcase
   end

   always_comb begin
      busy     = state_q != S_IDLE;
      done     = state_q == S_DONE;
      stk_pop  = (state_q == S_POPA) || (state_q == S_POPB);
      stk_tos  = state_q == S_TOSA;
      stk_push = state_q == S_PUSHR;
      stk_din  = (state_q == S_PUSHR) ? push_val : '0;
   end

   always_comb begin
      depth_d = depth_q;
      if (stk_push)     depth_d = depth_q + DEPTH_W'(1);
      else if (stk_pop) depth_d = depth_q - DEPTH_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q     <= '0;
         imm_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         depth_q  <= '0;
      end else begin
         depth_q <= depth_d;
         if (accept) begin
            op_q  <= op;
            imm_q <= imm;
            err_q <= !cmd_ok;
         end
         if (state_q == S_CAPA) a_q <= stk_dout;
         if (state_q == S_CAPB) b_q <= stk_dout;
         if (state_q == S_CAPA && op_q_read) result_q <= stk_dout;
         if (state_q == S_PUSHR) result_q <= push_val;
      end
   end

   assign result = result_q;
   assign err    = err_q;
   assign depth  = depth_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a behavioural 32-entry stack on the strobe side.
module tb_stack_sequencer;

   localparam logic [2:0] OP_PUSH = 3'd0, OP_POP = 3'd1, OP_TOS = 3'd2, OP_ADD = 3'd3;
   localparam logic [2:0] OP_SUB = 3'd4, OP_AND = 3'd5, OP_NOT = 3'd6, OP_DUP = 3'd7;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [2:0] op = 3'd0;
   logic [7:0] imm = 8'd0;
   logic       busy, done, err, stk_push, stk_pop, stk_tos;
   logic [7:0] result, stk_din, stk_dout;
   logic [5:0] depth;

   int checks = 0;
   int failures = 0;
   int proto_bad = 0;
   int lat, npush, npop, ntos;

   stack_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .imm(imm),
      .busy(busy), .done(done), .result(result), .err(err), .depth(depth),
      .stk_din(stk_din), .stk_push(stk_push), .stk_pop(stk_pop), .stk_tos(stk_tos),
      .stk_dout(stk_dout)
   );

   always #5 clk = ~clk;

   // behavioural stack: registered dout valid the cycle after pop/tos
   logic [7:0] smem [0:31];
   int         sp;
   always @(posedge clk) begin
      if (rst) begin
         sp <= 0;
         stk_dout <= 8'd0;
      end else if (stk_push) begin
         if (sp < 32) smem[sp] <= stk_din;
         sp <= sp + 1;
      end else if (stk_pop) begin
         if (sp > 0) stk_dout <= smem[sp-1];
         sp <= sp - 1;
      end else if (stk_tos) begin
         if (sp > 0) stk_dout <= smem[sp-1];
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (int'(stk_push) + int'(stk_pop) + int'(stk_tos) > 1) proto_bad++;
         if (!stk_push && stk_din !== 8'd0) proto_bad++;
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // issue one command; lat = cycles from accepting edge to done (0 = timeout)
   task automatic do_cmd(input logic [2:0] o, input logic [7:0] v);
      @(posedge clk);
      #1 start = 1'b1; op = o; imm = v;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0; npush = 0; npop = 0; ntos = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         npush += int'(stk_push);
         npop  += int'(stk_pop);
         ntos  += int'(stk_tos);
         if (done) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (result !== 8'd0) begin failures++; $display("FAIL reset_result got=%0d exp=0", result); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
      checks++; if (depth !== 6'd0) begin failures++; $display("FAIL reset_depth got=%0d exp=0", depth); end
      checks++; if ({stk_push, stk_pop, stk_tos} !== 3'b000 || stk_din !== 8'd0) begin
         failures++; $display("FAIL reset_strobes got=%b din=%0d exp=000 din=0", {stk_push, stk_pop, stk_tos}, stk_din);
      end
   endtask

   task automatic test_arith();
      do_cmd(OP_PUSH, 8'd5);
      checks++; if (lat !== 2) begin failures++; $display("FAIL push_latency got=%0d exp=2", lat); end
      checks++; if (result !== 8'd5 || npush !== 1) begin failures++; $display("FAIL push5 got=%0d pushes=%0d exp=5 pushes=1", result, npush); end
      do_cmd(OP_PUSH, 8'd3);
      do_cmd(OP_SUB, 8'd0);
      checks++; if (lat !== 6) begin failures++; $display("FAIL sub_latency got=%0d exp=6", lat); end
      checks++; if (result !== 8'd2) begin failures++; $display("FAIL sub_result got=%0d exp=2", result); end
      checks++; if (depth !== 6'd1 || npop !== 2 || npush !== 1) begin
         failures++; $display("FAIL sub_depth got=%0d pops=%0d pushes=%0d exp=1 2 1", depth, npop, npush);
      end
      do_cmd(OP_POP, 8'd0);
      checks++; if (lat !== 3 || result !== 8'd2 || depth !== 6'd0) begin
         failures++; $display("FAIL pop_after_sub got lat=%0d res=%0d depth=%0d exp 3 2 0", lat, result, depth);
      end
   endtask

   task automatic test_add_not();
      do_cmd(OP_PUSH, 8'd200);
      do_cmd(OP_PUSH, 8'd100);
      do_cmd(OP_ADD, 8'd0);
      checks++; if (result !== 8'd44 || depth !== 6'd1) begin
         failures++; $display("FAIL add_wrap got res=%0d depth=%0d exp 44 1", result, depth);
      end
      do_cmd(OP_PUSH, 8'h0F);
      do_cmd(OP_NOT, 8'd0);
      checks++; if (lat !== 4 || result !== 8'hF0 || depth !== 6'd2) begin
         failures++; $display("FAIL not got lat=%0d res=%0h depth=%0d exp 4 f0 2", lat, result, depth);
      end
      do_cmd(OP_DUP, 8'd0);
      checks++; if (lat !== 4 || result !== 8'hF0 || depth !== 6'd3 || ntos !== 1 || npop !== 0) begin
         failures++; $display("FAIL dup got lat=%0d res=%0h depth=%0d tos=%0d pops=%0d exp 4 f0 3 1 0", lat, result, depth, ntos, npop);
      end
      do_cmd(OP_AND, 8'd0);
      checks++; if (result !== 8'hF0 || depth !== 6'd2) begin
         failures++; $display("FAIL and got res=%0h depth=%0d exp f0 2", result, depth);
      end
   endtask

   task automatic test_underflow();
      do_reset();
      do_cmd(OP_ADD, 8'd0);
      checks++; if (lat !== 1 || err !== 1'b1) begin failures++; $display("FAIL underflow got lat=%0d err=%b exp 1 1", lat, err); end
      checks++; if (npush + npop + ntos !== 0 || depth !== 6'd0 || result !== 8'd0) begin
         failures++; $display("FAIL underflow_side got strobes=%0d depth=%0d res=%0d exp 0 0 0", npush + npop + ntos, depth, result);
      end
      do_cmd(OP_PUSH, 8'd7);
      checks++; if (err !== 1'b0 || result !== 8'd7 || depth !== 6'd1) begin
         failures++; $display("FAIL err_clear got err=%b res=%0d depth=%0d exp 0 7 1", err, result, depth);
      end
   endtask

   task automatic test_overflow();
      int nerr = 0;
      do_reset();
      for (int i = 0; i < 32; i++) begin
         do_cmd(OP_PUSH, 8'(i));
         if (err) nerr++;
      end
      checks++; if (depth !== 6'd32 || nerr !== 0) begin failures++; $display("FAIL fill got depth=%0d errs=%0d exp 32 0", depth, nerr); end
      do_cmd(OP_PUSH, 8'd99);
      checks++; if (lat !== 1 || err !== 1'b1 || npush !== 0 || depth !== 6'd32 || result !== 8'd31) begin
         failures++; $display("FAIL overflow got lat=%0d err=%b pushes=%0d depth=%0d res=%0d exp 1 1 0 32 31", lat, err, npush, depth, result);
      end
      do_cmd(OP_TOS, 8'd0);
      checks++; if (lat !== 3 || result !== 8'd31 || depth !== 6'd32 || err !== 1'b0) begin
         failures++; $display("FAIL tos_full got lat=%0d res=%0d depth=%0d err=%b exp 3 31 32 0", lat, result, depth, err);
      end
      do_cmd(OP_POP, 8'd0);
      checks++; if (result !== 8'd31 || depth !== 6'd31) begin failures++; $display("FAIL pop1 got res=%0d depth=%0d exp 31 31", result, depth); end
      do_cmd(OP_POP, 8'd0);
      checks++; if (result !== 8'd30 || depth !== 6'd30) begin failures++; $display("FAIL pop2 got res=%0d depth=%0d exp 30 30", result, depth); end
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      do_reset();
      do_cmd(OP_PUSH, 8'd10);
      do_cmd(OP_PUSH, 8'd4);
      @(posedge clk);
      #1 start = 1'b1; op = OP_ADD; imm = 8'd0;
      @(posedge clk);
      // start stays high with a different command while ADD is in flight
      #1 op = OP_PUSH; imm = 8'h55;
      lat = 0; npush = 0; npop = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         npush += int'(stk_push);
         npop  += int'(stk_pop);
         if (done) begin lat = n; break; end
      end
      checks++; if (lat !== 6 || result !== 8'd14 || npush !== 1 || npop !== 2) begin
         failures++; $display("FAIL add_held_start got lat=%0d res=%0d pushes=%0d pops=%0d exp 6 14 1 2", lat, result, npush, npop);
      end
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_after_done got busy=%b exp 0", busy); end
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (done) begin lat = n; break; end
      end
      checks++; if (lat !== 2 || result !== 8'h55 || depth !== 6'd2) begin
         failures++; $display("FAIL b2b_push got lat=%0d res=%0h depth=%0d exp 2 55 2", lat, result, depth);
      end
      // abort an ADD while it sits in CAPB
      @(posedge clk);
      #1 start = 1'b1; op = OP_ADD;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (busy !== 1'b1 || depth !== 6'd0) begin
         failures++; $display("FAIL capb_reach got busy=%b depth=%0d exp 1 0", busy, depth);
      end
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         if (stk_push || stk_pop || stk_tos || done || busy) bad++;
      end
      checks++; if (bad !== 0 || depth !== 6'd0) begin
         failures++; $display("FAIL reset_abort got bad=%0d depth=%0d exp 0 0", bad, depth);
      end
      checks++; if (proto_bad !== 0) begin failures++; $display("FAIL strobe_onehot got=%0d exp=0", proto_bad); end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_add_not();
      test_underflow();
      test_overflow();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
